i2s_tdm_tx: RTL and testbench

- Parametrised serial audio transmitter for the DAC path; successor to the fixed stereo I2S driver behind DAC_I2S_CLK/WS/DATA.
- Generalised in sample width, channel count (stereo I2S or multi-slot TDM) and framing mode (I2S or left-justified).
- Adds a frame FIFO with valid/ready handshake and underrun reporting.
- Sits between the audio sample producer (fed from SD card data) and the board DAC pins.

---
 rtl/i2s_tdm_tx.sv | 211 +++++++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
// Serial audio transmitter (I2S stereo or multi-slot TDM) with a frame FIFO.
// Frames are popped at slot-0 boundaries and shifted out MSB first on the bit clock.
module i2s_tdm_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CHANNELS     = 2,
  parameter int CLK_DIV      = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic                             enable,
  input  logic                             mode,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             underrun,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             DAC_I2S_CLK,
  output logic                             DAC_I2S_WS,
  output logic                             DAC_I2S_DATA
);
  localparam int FW     = CHANNELS * SAMPLE_WIDTH;
  localparam int SLOT_W = $clog2(FW);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FW - 1);
  localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sck_q, sck_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [FW-1:0]     sr_q, sr_d;
  logic              dly_q, dly_d;
  logic              mode_q, mode_d;
  logic              ws_q, ws_d;
  logic              data_q, data_d;
  logic              underrun_q, underrun_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     mem_q [FIFO_DEPTH];

  logic              push_s;
  logic              pop_s;
  logic              load_s;
  logic              fall_s;
  logic              bit_s;
  logic [FW-1:0]     frame_s;

  // Word select per slot; for TDM the I2S-style sync pulse sits in the slot before the frame.
  function automatic logic ws_for(input logic [SLOT_W-1:0] slot, input logic lj);
    logic ws;
    if (CHANNELS == 2) begin
      ws = (slot >= SLOT_W'(SAMPLE_WIDTH));
    end else if (lj) begin
      ws = (slot == '0);
    end else begin
      ws = (slot == LAST_SLOT);
    end
    return ws;
  endfunction

  assign in_ready     = (level_q < FULL_LVL);
  assign push_s       = in_valid && in_ready;
  assign fall_s       = (state_q == RUN) && sck_q && (div_q == DIV_TC);
  assign underrun     = underrun_q;
  assign fifo_level   = level_q;
  assign DAC_I2S_CLK  = sck_q;
  assign DAC_I2S_WS   = ws_q;
  assign DAC_I2S_DATA = data_q;

  // Next-state logic for the bit clock, slot sequencer, shift path and FIFO pointers.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sck_d      = sck_q;
    slot_d     = slot_q;
    sr_d       = sr_q;
    dly_d      = dly_q;
    mode_d     = mode_q;
    ws_d       = ws_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    load_s     = 1'b0;
    pop_s      = 1'b0;
    bit_s      = 1'b0;
    frame_s    = '0;

    case (state_q)
      IDLE: begin
        div_d  = '0;
        sck_d  = 1'b0;
        ws_d   = 1'b0;
        data_d = 1'b0;
        dly_d  = 1'b0;
        slot_d = '0;
        if (enable) begin
          load_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (div_q == DIV_TC) begin
          div_d = '0;
          sck_d = ~sck_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (fall_s) begin
          if (slot_q == LAST_SLOT) begin
            if (enable) begin
              load_s = 1'b1;
            end else begin
              state_d = IDLE;
              ws_d    = 1'b0;
              data_d  = 1'b0;
              dly_d   = 1'b0;
              slot_d  = '0;
            end
          end else begin
            bit_s  = sr_q[FW-1];
            sr_d   = sr_q << 1;
            slot_d = slot_q + SLOT_W'(1);
            ws_d   = ws_for(slot_q + SLOT_W'(1), mode_q);
            data_d = mode_q ? bit_s : dly_q;
            dly_d  = bit_s;
          end
        end else begin
          slot_d = slot_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame boundary: slot 0 of a new frame, from the FIFO or as silence.
    if (load_s) begin
      mode_d     = mode;
      slot_d     = '0;
      pop_s      = (level_q != '0);
      frame_s    = pop_s ? mem_q[rd_ptr_q] : '0;
      underrun_d = ~pop_s;
      bit_s      = frame_s[FW-1];
      sr_d       = frame_s << 1;
      data_d     = mode ? bit_s : dly_q;
      dly_d      = bit_s;
      ws_d       = ws_for('0, mode);
    end else begin
      pop_s = 1'b0;
    end

    level_d  = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  // State, counters and registered pin drivers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sck_q      <= 1'b0;
      slot_q     <= '0;
      sr_q       <= '0;
      dly_q      <= 1'b0;
      mode_q     <= 1'b0;
      ws_q       <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      slot_q     <= slot_d;
      sr_q       <= sr_d;
      dly_q      <= dly_d;
      mode_q     <= mode_d;
      ws_q       <= ws_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Frame storage.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed self-checking bench: stereo I2S/left-justified instance and a 4-channel TDM instance.
module tb_i2s_tdm_tx;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset;
  logic        a_en, a_mode, a_valid, a_ready, a_under, a_sck, a_ws, a_data;
  logic [31:0] a_in;
  logic [2:0]  a_level;
  logic        b_en, b_mode, b_valid, b_ready, b_under, b_sck, b_ws, b_data;
  logic [95:0] b_in;
  logic [2:0]  b_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] cap_d, cap_w;
  int rise_first, rise_prev, rise_last;

  always @(posedge CLK) cyc <= cyc + 1;

  i2s_tdm_tx #(.SAMPLE_WIDTH(16), .CHANNELS(2), .CLK_DIV(4), .FIFO_DEPTH(4)) dut_a (
    .CLK(CLK), .Reset(Reset), .enable(a_en), .mode(a_mode), .in_data(a_in),
    .in_valid(a_valid), .in_ready(a_ready), .underrun(a_under), .fifo_level(a_level),
    .DAC_I2S_CLK(a_sck), .DAC_I2S_WS(a_ws), .DAC_I2S_DATA(a_data));

  i2s_tdm_tx #(.SAMPLE_WIDTH(24), .CHANNELS(4), .CLK_DIV(2), .FIFO_DEPTH(4)) dut_b (
    .CLK(CLK), .Reset(Reset), .enable(b_en), .mode(b_mode), .in_data(b_in),
    .in_valid(b_valid), .in_ready(b_ready), .underrun(b_under), .fifo_level(b_level),
    .DAC_I2S_CLK(b_sck), .DAC_I2S_WS(b_ws), .DAC_I2S_DATA(b_data));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at a negedge after the frame has been accepted.
  task automatic push(input int which, input logic [95:0] d);
    int g = 0;
    if (which == 0) begin a_in = d[31:0]; a_valid = 1'b1; end
    else begin b_in = d; b_valid = 1'b1; end
    while (((which == 0) ? !a_ready : !b_ready) && g < 100) begin
      @(negedge CLK);
      g++;
    end
    checks++;
    if (g >= 100) begin
      errors++;
      $display("FAIL push_timeout: in_ready low for %0d cycles, expected 1", g);
    end
    @(posedge CLK);
    @(negedge CLK);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic reset_cap();
    cap_d = '0;
    cap_w = '0;
    rise_first = -1;
    rise_prev = 0;
    rise_last = 0;
  endtask

  // Samples DATA/WS at each rising bit-clock edge, newest slot in the LSB.
  task automatic capture(input int which, input int n);
    int got = 0;
    int guard = 0;
    logic prev, s;
    prev = (which == 0) ? a_sck : b_sck;
    while (got < n && guard < n * 40 + 200) begin
      @(negedge CLK);
      guard++;
      s = (which == 0) ? a_sck : b_sck;
      if (s && !prev) begin
        cap_d = {cap_d[126:0], (which == 0) ? a_data : b_data};
        cap_w = {cap_w[126:0], (which == 0) ? a_ws : b_ws};
        if (rise_first < 0) rise_first = cyc;
        rise_prev = rise_last;
        rise_last = cyc;
        got++;
      end
      prev = s;
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL capture_timeout: got %0d slots, expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    a_en = 1'b0; a_mode = 1'b0; a_valid = 1'b0; a_in = '0;
    b_en = 1'b0; b_mode = 1'b0; b_valid = 1'b0; b_in = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({a_ready, a_level, a_under, a_sck, a_ws, a_data} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_a: got %b, expected 10000000", {a_ready, a_level, a_under, a_sck, a_ws, a_data});
    end
    checks++;
    if ({b_ready, b_level, b_under, b_sck, b_ws, b_data} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_b: got %b, expected 10000000", {b_ready, b_level, b_under, b_sck, b_ws, b_data});
    end
    Reset = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if ({a_sck, a_ws, a_data, a_under} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, expected 0000", {a_sck, a_ws, a_data, a_under});
    end
  endtask

  task automatic test_left_justified();
    push(0, 96'hA5F0_0F5A);
    checks++;
    if (a_level !== 3'd1) begin
      errors++;
      $display("FAIL lj_level_push: got %0d, expected 1", a_level);
    end
    a_mode = 1'b1;
    a_en = 1'b1;
    @(negedge CLK);
    a_en = 1'b0;
    checks++;
    if ({a_level, a_under} !== 4'b0000) begin
      errors++;
      $display("FAIL lj_pop: level/underrun %b, expected 0000", {a_level, a_under});
    end
    reset_cap();
    capture(0, 32);
    checks++;
    if (cap_d[31:0] !== 32'hA5F0_0F5A) begin
      errors++;
      $display("FAIL lj_data: got %h, expected a5f00f5a", cap_d[31:0]);
    end
    checks++;
    if (cap_w[31:0] !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL lj_ws: got %h, expected 0000ffff", cap_w[31:0]);
    end
    checks++;
    if (rise_last - rise_prev !== 8) begin
      errors++;
      $display("FAIL sck_period: got %0d CLK, expected 8", rise_last - rise_prev);
    end
    repeat (20) @(negedge CLK);
    checks++;
    if ({a_sck, a_ws, a_data} !== 3'b000) begin
      errors++;
      $display("FAIL lj_idle: got %b, expected 000", {a_sck, a_ws, a_data});
    end
  endtask

  task automatic test_i2s_back_to_back();
    logic [31:0] f, g;
    logic [63:0] exp_d;
    f = 32'hA5F0_0F5A;
    g = 32'h3C96_E187;
    exp_d = {1'b0, f, g[31:1]};
    push(0, {64'h0, f});
    push(0, {64'h0, g});
    checks++;
    if (a_level !== 3'd2) begin
      errors++;
      $display("FAIL i2s_level: got %0d, expected 2", a_level);
    end
    a_mode = 1'b0;
    a_en = 1'b1;
    @(negedge CLK);
    reset_cap();
    capture(0, 40);
    a_en = 1'b0;
    capture(0, 24);
    checks++;
    if (cap_d[63:0] !== exp_d) begin
      errors++;
      $display("FAIL i2s_data: got %h, expected %h", cap_d[63:0], exp_d);
    end
    checks++;
    if (cap_w[63:0] !== 64'h0000_FFFF_0000_FFFF) begin
      errors++;
      $display("FAIL i2s_ws: got %h, expected 0000ffff0000ffff", cap_w[63:0]);
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_underrun();
    int pulses = 0;
    int highs = 0;
    int t1 = -1, t2 = -1, t3 = -1;
    logic prev_u = 1'b0;
    logic data_seen = 1'b0;
    a_mode = 1'b1;
    a_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      if (i == 600) a_en = 1'b0;
      if (a_under) highs++;
      if (a_under && !prev_u) begin
        pulses++;
        if (pulses == 1) t1 = i;
        if (pulses == 2) t2 = i;
        if (pulses == 3) t3 = i;
      end
      prev_u = a_under;
      data_seen = data_seen | a_data;
    end
    checks++;
    if (pulses !== 3 || highs !== 3) begin
      errors++;
      $display("FAIL underrun_count: pulses %0d high-cycles %0d, expected 3 and 3", pulses, highs);
    end
    checks++;
    if (t2 - t1 !== 256 || t3 - t2 !== 256) begin
      errors++;
      $display("FAIL underrun_spacing: got %0d and %0d, expected 256 and 256", t2 - t1, t3 - t2);
    end
    checks++;
    if (data_seen !== 1'b0) begin
      errors++;
      $display("FAIL underrun_data: DATA went %b, expected 0", data_seen);
    end
    checks++;
    if (a_sck !== 1'b0) begin
      errors++;
      $display("FAIL underrun_stop: SCK %b, expected 0", a_sck);
    end
  endtask

  task automatic test_fifo_full_and_reset();
    int g = 0;
    int rel;
    logic [31:0] f2;
    f2 = 32'hC3A5_5A3C;
    for (int i = 0; i < 4; i++) push(0, {64'h0, 32'h1111_0000 + 32'(i)});
    checks++;
    if ({a_ready, a_level} !== 4'b0100) begin
      errors++;
      $display("FAIL fifo_full: ready/level %b, expected 0100", {a_ready, a_level});
    end
    a_in = 32'h1111_0004;
    a_valid = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if ({a_ready, a_level} !== 4'b0100) begin
      errors++;
      $display("FAIL fifo_hold: ready/level %b, expected 0100", {a_ready, a_level});
    end
    a_mode = 1'b1;
    a_en = 1'b1;
    while (!a_ready && g < 50) begin
      @(negedge CLK);
      g++;
    end
    @(posedge CLK);
    @(negedge CLK);
    a_valid = 1'b0;
    checks++;
    if (g >= 50 || a_level !== 3'd4) begin
      errors++;
      $display("FAIL fifo_refill: level %0d after %0d waits, expected 4", a_level, g);
    end
    reset_cap();
    capture(0, 32);
    checks++;
    if (cap_d[31:0] !== 32'h1111_0000) begin
      errors++;
      $display("FAIL fifo_order: got %h, expected 11110000", cap_d[31:0]);
    end
    capture(0, 20);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({a_sck, a_ws, a_data, a_under, a_level, a_ready} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL midframe_reset: got %b, expected 00000001", {a_sck, a_ws, a_data, a_under, a_level, a_ready});
    end
    @(negedge CLK);
    Reset = 1'b1;
    rel = cyc;
    @(negedge CLK);
    checks++;
    if (a_under !== 1'b1) begin
      errors++;
      $display("FAIL restart_underrun: got %b, expected 1", a_under);
    end
    push(0, {64'h0, f2});
    reset_cap();
    capture(0, 40);
    checks++;
    if (rise_first - rel !== 5) begin
      errors++;
      $display("FAIL restart_slot0: first rise after %0d CLK, expected 5", rise_first - rel);
    end
    a_en = 1'b0;
    capture(0, 24);
    checks++;
    if (cap_d[63:0] !== {32'h0, f2} || cap_w[63:0] !== 64'h0000_FFFF_0000_FFFF) begin
      errors++;
      $display("FAIL restart_frames: data %h ws %h, expected 00000000c3a55a3c 0000ffff0000ffff", cap_d[63:0], cap_w[63:0]);
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_tdm();
    logic [95:0] t, exp_w;
    t = {24'h80_0001, 24'h40_00C3, 24'h2A_AA55, 24'hF0_F00F};
    push(1, t);
    b_mode = 1'b1;
    b_en = 1'b1;
    @(negedge CLK);
    b_en = 1'b0;
    reset_cap();
    capture(1, 96);
    exp_w = '0;
    exp_w[95] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cap_d[95 - 24*c -: 24] !== t[95 - 24*c -: 24]) begin
        errors++;
        $display("FAIL tdm_ch%0d: got %h, expected %h", c, cap_d[95 - 24*c -: 24], t[95 - 24*c -: 24]);
      end
    end
    checks++;
    if (cap_w[95:0] !== exp_w) begin
      errors++;
      $display("FAIL tdm_ws_lj: got %h, expected %h", cap_w[95:0], exp_w);
    end
    checks++;
    if (rise_last - rise_prev !== 4) begin
      errors++;
      $display("FAIL tdm_sck_period: got %0d, expected 4", rise_last - rise_prev);
    end
    repeat (20) @(negedge CLK);
    push(1, t);
    b_mode = 1'b0;
    b_en = 1'b1;
    @(negedge CLK);
    b_en = 1'b0;
    reset_cap();
    capture(1, 96);
    checks++;
    if (cap_d[95:0] !== {1'b0, t[95:1]}) begin
      errors++;
      $display("FAIL tdm_i2s_data: got %h, expected %h", cap_d[95:0], {1'b0, t[95:1]});
    end
    checks++;
    if (cap_w[95:0] !== 96'h1) begin
      errors++;
      $display("FAIL tdm_ws_i2s: got %h, expected 1", cap_w[95:0]);
    end
    repeat (20) @(negedge CLK);
    checks++;
    if ({b_sck, b_ws, b_data} !== 3'b000) begin
      errors++;
      $display("FAIL tdm_idle: got %b, expected 000", {b_sck, b_ws, b_data});
    end
  endtask

  initial begin
    test_reset();
    test_left_justified();
    test_i2s_back_to_back();
    test_underrun();
    test_fifo_full_and_reset();
    test_tdm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
